// File: rtl/ro_reg_change_logger.sv
// Logs every change of a monitored read-only register value into a small FIFO drained by a valid/ready stream.
// Optional macro RO_REG_CHANGE_DELTA_EN adds a saturating idle-cycle delta per logged entry.
module ro_reg_change_logger #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DELTA_WIDTH = 8
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic [DATA_WIDTH-1:0]         VALUE_IN,
  input  logic                          ENABLE,
  input  logic                          CLEAR,
  output logic                          EVT_VALID,
  input  logic                          EVT_READY,
  output logic [DATA_WIDTH-1:0]         EVT_DATA,
  output logic [DELTA_WIDTH-1:0]        EVT_DELTA,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          OVERFLOW
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;

  logic push, pop, full, accept, drop;

  // Event qualification; CLEAR overrides both push and pop.
  always_comb begin
    push   = (VALUE_IN != prev_q) && ENABLE && !CLEAR;
    pop    = valid_q && EVT_READY && !CLEAR;
    full   = (level_q == LVL_W'(FIFO_DEPTH));
    accept = push && (!full || pop);
    drop   = push && full && !pop;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
    if (CLEAR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(accept) - LVL_W'(pop);
      if (drop)   ovf_d = 1'b1;
    end
    valid_d = (level_d != '0);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      prev_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      prev_q   <= VALUE_IN;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is reset so the head reads 0 while in reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) data_mem_q[i] <= '0;
    end else if (accept) begin
      data_mem_q[wr_ptr_q] <= VALUE_IN;
    end
  end

  assign EVT_VALID = valid_q;
  assign EVT_DATA  = data_mem_q[rd_ptr_q];
  assign LEVEL     = level_q;
  assign OVERFLOW  = ovf_q;

`ifdef RO_REG_CHANGE_DELTA_EN
  logic [DELTA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DELTA_WIDTH-1:0] delta_mem_q [FIFO_DEPTH];

  // Idle counter restarts on every qualified change, even a dropped one.
  always_comb begin
    cnt_d = cnt_q;
    if (CLEAR || push) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + DELTA_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) delta_mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) delta_mem_q[wr_ptr_q] <= cnt_q;
    end
  end

  assign EVT_DELTA = delta_mem_q[rd_ptr_q];
`else
  assign EVT_DELTA = '0;
`endif

endmodule
